ttt_game_ctrl: RTL and testbench

Sequences a two-player tic-tac-toe game around the 3x3 board datapath. Owns the board register file and arbitrates move requests from two player ports, granting only the player whose turn it is. Rejects illegal moves and evaluates the eight win lines after every accepted move. Declares win, draw or timeout forfeit, and holds the result until a new game is requested.

---
 rtl/ttt_game_ctrl_if.sv | 40 ++++
 rtl/ttt_game_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ttt_game_ctrl_if.sv
// Host/player-side bundle for ttt_game_ctrl: game control, two move handshakes and board/result status.
// The timeout status bit exists only when TTT_TURN_TIMEOUT_EN is defined.
interface ttt_game_ctrl_if;
    logic        start;
    logic        new_game;
    logic        p1_valid;
    logic [3:0]  p1_pos;
    logic        p1_ready;
    logic        p2_valid;
    logic [3:0]  p2_pos;
    logic        p2_ready;
    logic [17:0] board;
    logic [1:0]  turn;
    logic        illegal;
    logic [3:0]  move_count;
    logic        game_over;
    logic [1:0]  winner;
    logic        draw;
`ifdef TTT_TURN_TIMEOUT_EN
    logic        timeout;
`endif

    modport master (
`ifdef TTT_TURN_TIMEOUT_EN
        input  timeout,
`endif
        output start, new_game, p1_valid, p1_pos, p2_valid, p2_pos,
        input  p1_ready, p2_ready, board, turn, illegal, move_count,
               game_over, winner, draw
    );

    modport slave (
`ifdef TTT_TURN_TIMEOUT_EN
        output timeout,
`endif
        input  start, new_game, p1_valid, p1_pos, p2_valid, p2_pos,
        output p1_ready, p2_ready, board, turn, illegal, move_count,
               game_over, winner, draw
    );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Two-player tic-tac-toe sequencer: owns the board, grants moves by turn, detects win/draw.
// Optional per-turn forfeit timer enabled by defining TTT_TURN_TIMEOUT_EN.
module ttt_game_ctrl #(
    parameter int FIRST_PLAYER = 1,
    parameter int TURN_TIMEOUT = 1000
) (
    input logic             clk,
    input logic             rst_n,
    ttt_game_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1_TURN,
        S_P2_TURN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam state_t FIRST_TURN = (FIRST_PLAYER == 2) ? S_P2_TURN : S_P1_TURN;

    state_t      r_state;
    logic [17:0] r_board;
    logic [3:0]  r_move_count;
    logic [1:0]  r_mover;
    logic        r_illegal;
    logic [1:0]  r_winner;
    logic        r_draw;

    logic        w_in_turn;
    logic [1:0]  w_code;
    logic        w_valid;
    logic [3:0]  w_pos;
    logic        w_legal;
    logic        w_win;
    logic [1:0]  w_turn;

`ifdef TTT_TURN_TIMEOUT_EN
    localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TURN_TIMEOUT - 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout;
    assign bus.timeout = r_timeout;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TURN_TIMEOUT != 0);
`endif

    // Out-of-range positions read as occupied so they fall out as illegal.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] p);
        logic [1:0] c;
        c = 2'b11;
        for (int i = 0; i < 9; i++) begin
            if (p == 4'(i)) c = b[2*i +: 2];
        end
        return c;
    endfunction

    function automatic logic [17:0] put_cell(input logic [17:0] b, input logic [3:0] p,
                                             input logic [1:0] code);
        logic [17:0] nb;
        nb = b;
        for (int i = 0; i < 9; i++) begin
            if (p == 4'(i)) nb[2*i +: 2] = code;
        end
        return nb;
    endfunction

    function automatic logic line_win(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c);
        return (a != 2'b00) && (a == b) && (b == c);
    endfunction

    function automatic logic any_win(input logic [17:0] b);
        return line_win(b[1:0],   b[3:2],   b[5:4])   ||
               line_win(b[7:6],   b[9:8],   b[11:10]) ||
               line_win(b[13:12], b[15:14], b[17:16]) ||
               line_win(b[1:0],   b[7:6],   b[13:12]) ||
               line_win(b[3:2],   b[9:8],   b[15:14]) ||
               line_win(b[5:4],   b[11:10], b[17:16]) ||
               line_win(b[1:0],   b[9:8],   b[17:16]) ||
               line_win(b[5:4],   b[9:8],   b[13:12]);
    endfunction

    assign w_in_turn = (r_state == S_P1_TURN) || (r_state == S_P2_TURN);
    assign w_code    = (r_state == S_P2_TURN) ? 2'b10 : 2'b01;
    assign w_pos     = (r_state == S_P2_TURN) ? bus.p2_pos : bus.p1_pos;
    assign w_valid   = ((r_state == S_P1_TURN) && bus.p1_valid) ||
                       ((r_state == S_P2_TURN) && bus.p2_valid);
    assign w_legal   = (w_pos <= 4'd8) && (cell_at(r_board, w_pos) == 2'b00);
    assign w_win     = any_win(r_board);

    always_comb begin
        w_turn = 2'b00;
        case (r_state)
            S_P1_TURN: w_turn = 2'b01;
            S_P2_TURN: w_turn = 2'b10;
            S_CHECK:   w_turn = r_mover;
            default:   w_turn = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_board      <= '0;
            r_move_count <= '0;
            r_mover      <= '0;
            r_illegal    <= 1'b0;
            r_winner     <= '0;
            r_draw       <= 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_timeout    <= 1'b0;
`endif
        end else if (bus.new_game) begin
            r_state      <= S_IDLE;
            r_board      <= '0;
            r_move_count <= '0;
            r_mover      <= '0;
            r_illegal    <= 1'b0;
            r_winner     <= '0;
            r_draw       <= 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= FIRST_TURN;
`ifdef TTT_TURN_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                S_P1_TURN, S_P2_TURN: begin
                    if (w_valid && w_legal) begin
                        r_board <= put_cell(r_board, w_pos, w_code);
                        if (r_move_count != 4'd9) r_move_count <= r_move_count + 4'd1;
                        r_mover <= w_code;
                        r_state <= S_CHECK;
                    end else if (w_valid) begin
                        r_illegal <= 1'b1;
`ifdef TTT_TURN_TIMEOUT_EN
                        r_tmo_cnt <= '0;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_winner  <= w_code ^ 2'b11;
                        r_timeout <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                // Only the mover can have completed a line, so any line belongs to r_mover.
                S_CHECK: begin
                    if (w_win) begin
                        r_winner <= r_mover;
                        r_state  <= S_DONE;
                    end else if (r_move_count == 4'd9) begin
                        r_draw  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= (r_mover == 2'b01) ? S_P2_TURN : S_P1_TURN;
`ifdef TTT_TURN_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                S_DONE: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.p1_ready   = (r_state == S_P1_TURN);
    assign bus.p2_ready   = (r_state == S_P2_TURN);
    assign bus.turn       = w_turn;
    assign bus.board      = r_board;
    assign bus.illegal    = r_illegal;
    assign bus.move_count = r_move_count;
    assign bus.game_over  = (r_state == S_DONE);
    assign bus.winner     = r_winner;
    assign bus.draw       = r_draw;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: game-rule model compared every cycle plus literal checkpoints.
module tb_ttt_game_ctrl;
    localparam int TO = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    ttt_game_ctrl_if bus ();

    ttt_game_ctrl #(.FIRST_PLAYER(1), .TURN_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game-rule model: cells hold 0/1/2, phase 0 idle, 1/2 player to move, 3 line check, 4 over.
    int m_cells[9];
    int m_count, m_phase, m_mover, m_winner, m_tcnt;
    bit m_draw, m_illegal, m_timeout;

    function automatic bit trip(input int a, input int b, input int c);
        return (a != 0) && (a == b) && (b == c);
    endfunction

    function automatic bit m_has_line();
        bit hit;
        hit = trip(m_cells[0], m_cells[4], m_cells[8]) || trip(m_cells[2], m_cells[4], m_cells[6]);
        for (int r = 0; r < 3; r++) begin
            hit = hit || trip(m_cells[3*r], m_cells[3*r+1], m_cells[3*r+2]);
            hit = hit || trip(m_cells[r], m_cells[r+3], m_cells[r+6]);
        end
        return hit;
    endfunction

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cells[i]);
        return b;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 9; i++) m_cells[i] = 0;
        m_count = 0; m_phase = 0; m_mover = 0; m_winner = 0; m_tcnt = 0;
        m_draw = 0; m_illegal = 0; m_timeout = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear();
        end else if (bus.new_game) begin
            m_clear();
        end else begin
            int p, pos;
            bit v;
            m_illegal = 0;
            if (m_phase == 0) begin
                if (bus.start) begin m_phase = 1; m_tcnt = 0; end
            end else if (m_phase == 1 || m_phase == 2) begin
                p   = m_phase;
                v   = (p == 1) ? bus.p1_valid : bus.p2_valid;
                pos = (p == 1) ? int'(bus.p1_pos) : int'(bus.p2_pos);
                if (v && pos < 9 && m_cells[pos % 9] == 0) begin
                    m_cells[pos] = p;
                    m_count++;
                    m_mover = p;
                    m_phase = 3;
                end else if (v) begin
                    m_illegal = 1;
                    m_tcnt = 0;
`ifdef TTT_TURN_TIMEOUT_EN
                end else if (m_tcnt == TO - 1) begin
                    m_winner = 3 - p;
                    m_timeout = 1;
                    m_phase = 4;
`endif
                end else begin
                    m_tcnt++;
                end
            end else if (m_phase == 3) begin
                if (m_has_line()) begin
                    m_winner = m_mover; m_phase = 4;
                end else if (m_count == 9) begin
                    m_draw = 1; m_phase = 4;
                end else begin
                    m_phase = 3 - m_mover; m_tcnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_board", 32'(bus.board), 32'(m_board()));
            chk("cyc_move_count", 32'(bus.move_count), 32'(m_count));
            chk("cyc_turn", 32'(bus.turn), (m_phase == 1 || m_phase == 2) ? m_phase :
                                           (m_phase == 3) ? m_mover : 0);
            chk("cyc_p1_ready", 32'(bus.p1_ready), 32'(m_phase == 1));
            chk("cyc_p2_ready", 32'(bus.p2_ready), 32'(m_phase == 2));
            chk("cyc_illegal", 32'(bus.illegal), 32'(m_illegal));
            chk("cyc_game_over", 32'(bus.game_over), 32'(m_phase == 4));
            chk("cyc_winner", 32'(bus.winner), 32'(m_winner));
            chk("cyc_draw", 32'(bus.draw), 32'(m_draw));
`ifdef TTT_TURN_TIMEOUT_EN
            chk("cyc_timeout", 32'(bus.timeout), 32'(m_timeout));
`endif
        end
    end

    task automatic start_game();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic new_game();
        @(negedge clk) bus.new_game = 1'b1;
        @(negedge clk) bus.new_game = 1'b0;
    endtask

    task automatic play(input int p, input int pos);
        @(negedge clk);
        if (p == 1) begin bus.p1_valid = 1'b1; bus.p1_pos = 4'(pos); end
        else        begin bus.p2_valid = 1'b1; bus.p2_pos = 4'(pos); end
        @(negedge clk);
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
    endtask

    initial begin
        int seq[9];
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.new_game = 1'b0;
        bus.p1_valid = 1'b0; bus.p1_pos = '0;
        bus.p2_valid = 1'b0; bus.p2_pos = '0;
        repeat (2) @(negedge clk);
        chk("rst_board", 32'(bus.board), 0);
        chk("rst_turn", 32'(bus.turn), 0);
        chk("rst_ready", 32'({bus.p1_ready, bus.p2_ready}), 0);
        chk("rst_game_over", 32'(bus.game_over), 0);
        rst_n = 1'b1;

        // Row 0-1-2 won by P1
        start_game();
        play(1, 0); play(2, 3); play(1, 1); play(2, 4); play(1, 2);
        @(negedge clk);
        chk("row_game_over", 32'(bus.game_over), 1);
        chk("row_winner", 32'(bus.winner), 32'h1);
        chk("row_move_count", 32'(bus.move_count), 5);
        chk("row_board_low", 32'(bus.board[5:0]), 32'b010101);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        chk("done_ignores_start", 32'(bus.game_over), 1);
        new_game();

        // Occupied cell and out-of-range position rejected
        start_game();
        play(1, 4);
        @(negedge clk) begin bus.p2_valid = 1'b1; bus.p2_pos = 4'd4; end
        @(negedge clk) bus.p2_valid = 1'b0;
        chk("occ_illegal", 32'(bus.illegal), 1);
        chk("occ_p2_ready", 32'(bus.p2_ready), 1);
        chk("occ_board", 32'(bus.board), 32'h00100);
        @(negedge clk);
        chk("occ_illegal_one_cycle", 32'(bus.illegal), 0);
        bus.p2_valid = 1'b1; bus.p2_pos = 4'd9;
        @(negedge clk) bus.p2_valid = 1'b0;
        chk("pos9_illegal", 32'(bus.illegal), 1);
        play(2, 0);
        chk("after_illegal_count", 32'(bus.move_count), 2);
        chk("after_illegal_cell0", 32'(bus.board[1:0]), 32'h2);
        new_game();

        // Full-board draw
        seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        start_game();
        for (int i = 0; i < 9; i++) play((i % 2 == 0) ? 1 : 2, seq[i]);
        @(negedge clk);
        chk("draw_flag", 32'(bus.draw), 1);
        chk("draw_winner", 32'(bus.winner), 0);
        chk("draw_count", 32'(bus.move_count), 9);
        chk("draw_board", 32'(bus.board), 32'h16A59);
        new_game();

        // Out-of-turn request ignored, then P2 wins diagonal 2-4-6
        start_game();
        @(negedge clk) begin bus.p2_valid = 1'b1; bus.p2_pos = 4'd0; end
        @(negedge clk) bus.p2_valid = 1'b0;
        chk("oot_p2_ready", 32'(bus.p2_ready), 0);
        chk("oot_illegal", 32'(bus.illegal), 0);
        chk("oot_board", 32'(bus.board), 0);
        play(1, 0); play(2, 2); play(1, 1); play(2, 4); play(1, 5); play(2, 6);
        @(negedge clk);
        chk("diag_winner", 32'(bus.winner), 32'h2);
        chk("diag_game_over", 32'(bus.game_over), 1);
        new_game();

        // new_game beats a same-cycle legal move
        start_game();
        play(1, 0); play(2, 4);
        @(negedge clk) begin bus.new_game = 1'b1; bus.p1_valid = 1'b1; bus.p1_pos = 4'd8; end
        @(negedge clk) begin bus.new_game = 1'b0; bus.p1_valid = 1'b0; end
        chk("ng_board", 32'(bus.board), 0);
        chk("ng_count", 32'(bus.move_count), 0);
        chk("ng_turn", 32'(bus.turn), 0);
        chk("ng_illegal", 32'(bus.illegal), 0);
        chk("ng_p1_ready", 32'(bus.p1_ready), 0);

        // Asynchronous reset mid-game
        start_game();
        play(1, 0); play(2, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_board", 32'(bus.board), 0);
        chk("arst_count", 32'(bus.move_count), 0);
        chk("arst_turn", 32'(bus.turn), 0);
        chk("arst_ready", 32'({bus.p1_ready, bus.p2_ready}), 0);
        chk("arst_result", 32'({bus.game_over, bus.winner, bus.draw}), 0);
        @(negedge clk) rst_n = 1'b1;

`ifdef TTT_TURN_TIMEOUT_EN
        begin
            int waited;
            waited = 0;
            start_game();
            while (!bus.game_over && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk("tmo_cycles", 32'(waited), 32'(TO));
            chk("tmo_winner", 32'(bus.winner), 32'h2);
            chk("tmo_flag", 32'(bus.timeout), 1);
            new_game();
        end
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
